// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding and 74181 function-select codes for the slice sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] ALU_ADD    = 4'b1001;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b1011;
  localparam logic [3:0] ALU_XOR    = 4'b0110;
  localparam logic [3:0] ALU_PASS_A = 4'b1111;
endpackage

// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer: drives one external 4-bit 74181 slice nibble-serially to form a wide ALU
module alu_slice_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic [3:0]             in_s,
  input  logic                   in_m,
  input  logic                   in_cnb,
  output logic [3:0]             slice_a,
  output logic [3:0]             slice_b,
  output logic [3:0]             slice_s,
  output logic                   slice_m,
  output logic                   slice_cnb,
  input  logic [3:0]             slice_f,
  input  logic                   slice_cn4b,
  input  logic                   slice_aeb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_f,
  output logic                   out_cn4b,
  output logic                   out_aeb
);
  localparam int W = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [W-1:0] a_q, b_q, acc;
  logic [3:0] s_q;
  logic m_q, cnb_q, carry_q, aeb_acc, run, last;
  assign run = state == RUN;
  assign last = idx == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // slice pins are combinational from registered state so an async reset clears them without a clock
  always_comb begin
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (out_valid && out_ready ? IDLE : DONE);
    in_ready = state == IDLE;
    slice_a = run ? a_q[{idx, 2'b00} +: 4] : 4'h0;
    slice_b = run ? b_q[{idx, 2'b00} +: 4] : 4'h0;
    slice_s = run ? s_q : 4'h0;
    slice_m = run ? m_q : 1'b1;
    slice_cnb = run ? (idx == '0 ? cnb_q : carry_q) : 1'b1;
  end
  // DONE spends one cycle copying the accumulator into the output registers before out_valid rises
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      m_q <= 1'b1;
      cnb_q <= 1'b1;
      acc <= '0;
      aeb_acc <= 1'b0;
      carry_q <= 1'b1;
      out_valid <= 1'b0;
      out_f <= '0;
      out_cn4b <= 1'b1;
      out_aeb <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_q <= in_a;
        b_q <= in_b;
        s_q <= in_s;
        m_q <= in_m;
        cnb_q <= in_cnb;
        acc <= '0;
        aeb_acc <= 1'b1;
        idx <= '0;
      end
      if (run) begin
        acc[{idx, 2'b00} +: 4] <= slice_f;
        aeb_acc <= aeb_acc & slice_aeb;
        carry_q <= slice_cn4b;
        if (!last) idx <= idx + 1'b1;
      end
      if (state == DONE) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_f <= acc;
          out_cn4b <= carry_q;
          out_aeb <= aeb_acc;
        end else if (out_ready) out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb_alu_slice_sequencer: scoreboard bench with a behavioural 74181 slice and a wide-arithmetic reference
module tb_alu_slice_sequencer;
  import alu_seq_pkg::*;
  localparam int N = 4;
  localparam int W = 16;
  typedef struct packed {logic [W-1:0] f; logic c; logic e;} exp_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_m = 0, in_cnb = 1, in_ready;
  logic [W-1:0] in_a = '0, in_b = '0, out_f;
  logic [3:0] in_s = '0, slice_a, slice_b, slice_s, slice_f;
  logic slice_m, slice_cnb, slice_cn4b, slice_aeb;
  logic out_valid, out_ready = 1, out_cn4b, out_aeb;
  logic rand_ready = 0, force_ready = 1;
  logic [N-1:0] cnb_seen;
  int tests = 0, fails = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  alu_slice_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m), .in_cnb(in_cnb),
    .slice_a(slice_a), .slice_b(slice_b), .slice_s(slice_s), .slice_m(slice_m),
    .slice_cnb(slice_cnb), .slice_f(slice_f), .slice_cn4b(slice_cn4b), .slice_aeb(slice_aeb),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .out_cn4b(out_cn4b), .out_aeb(out_aeb)
  );
  // external 74181 slice: arithmetic F = X plus Y plus carry, logic F = not(X xor Y)
  logic [3:0] sx, sy;
  logic [4:0] ssum;
  always_comb begin
    sx = slice_a | (slice_s[0] ? slice_b : 4'h0) | (slice_s[1] ? ~slice_b : 4'h0);
    sy = (slice_s[3] ? slice_a & slice_b : 4'h0) | (slice_s[2] ? slice_a & ~slice_b : 4'h0);
    ssum = {1'b0, sx} + {1'b0, sy} + {4'h0, ~slice_cnb};
    slice_f = slice_m ? ~(sx ^ sy) : ssum[3:0];
    slice_cn4b = ~ssum[4];
    slice_aeb = slice_f == 4'hF;
  end
  function automatic exp_t model(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cnb);
    logic [W:0] x, y, sum;
    exp_t r;
    x = {1'b0, a | (s[0] ? b : '0) | (s[1] ? ~b : '0)};
    y = {1'b0, (s[3] ? a & b : '0) | (s[2] ? a & ~b : '0)};
    sum = x + y + {{W{1'b0}}, ~cnb};
    r.f = m ? ~(x[W-1:0] ^ y[W-1:0]) : sum[W-1:0];
    r.c = ~sum[W];
    r.e = &r.f;
    return r;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
  end
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        e = q.pop_front();
        check("out_f", out_f, e.f);
        check("out_cn4b", out_cn4b, e.c);
        check("out_aeb", out_aeb, e.e);
      end
    end
  end
  task automatic send(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cnb);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_a = a;
    in_b = b;
    in_s = s;
    in_m = m;
    in_cnb = cnb;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic collect();
    int n = 0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      cnb_seen[k] = slice_cnb;
    end
    n = N;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, N + 2);
    while (out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (out_valid) check("drain_timeout", 1, 0);
  endtask
  task automatic op(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cnb);
    send(a, b, s, m, cnb);
    collect();
  endtask
  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0] rs;
    logic rm, rc;
    int n;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_slice_m", slice_m, 1);
    check("rst_slice_cnb", slice_cnb, 1);
    check("rst_out_cn4b", out_cn4b, 1);
    check("rst_out_f", out_f, 0);
    rst_n = 1;
    @(negedge clk);
    q.push_back(exp_t'{16'h2201, 1'b1, 1'b0});
    op(16'h1234, 16'h0FCD, ALU_ADD, 0, 1);
    check("add_cnb_nib0", cnb_seen[0], 1);
    check("add_cnb_nib1", cnb_seen[1], 0);
    q.push_back(exp_t'{16'h0000, 1'b0, 1'b0});
    op(16'hFFFF, 16'h0001, ALU_ADD, 0, 1);
    check("ovf_cnb_nib123", cnb_seen[3:1], 3'b000);
    q.push_back(exp_t'{16'hFFFF, 1'b1, 1'b1});
    op(16'h5A5A, 16'h5A5A, ALU_SUB, 0, 1);
    q.push_back(exp_t'{16'h0000, 1'b0, 1'b0});
    op(16'h5A5A, 16'h5A5A, ALU_SUB, 0, 0);
    check("sub_cnb_nib0", cnb_seen[0], 0);
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = i < 4 ? (i[0] ? ALU_AND : ALU_XOR) : 4'($urandom);
      rm = i < 4 ? 1'b1 : 1'($urandom);
      rc = 1'($urandom);
      q.push_back(model(ra, rb, rs, rm, rc));
      op(ra, rb, rs, rm, rc);
    end
    rand_ready = 0;
    force_ready = 0;
    q.push_back(exp_t'{16'h2345, 1'b1, 1'b0});
    send(16'h1234, 16'h1111, ALU_ADD, 0, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      in_a = 16'($urandom);
      @(negedge clk);
      check("bp_out_f", out_f, 16'h2345);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    force_ready = 1;
    repeat (3) @(negedge clk);
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    check("bp_queue_empty", q.size(), 0);
    send(16'h0F00, 16'h0300, ALU_ADD, 0, 1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_slice_a", slice_a, 0);
    check("arst_slice_s", slice_s, 0);
    check("arst_slice_m", slice_m, 1);
    check("arst_slice_cnb", slice_cnb, 1);
    check("arst_out_f", out_f, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    q.push_back(exp_t'{16'h0002, 1'b1, 1'b0});
    op(16'h0001, 16'h0001, ALU_ADD, 0, 1);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("final_queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
